// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI target engine, oversampled entirely in clk_i.
// Receives single-lane frames on SCK/NSS/MOSI, drives MISO, and exchanges
// words with external TX/RX FIFOs over valid/ready.
// Optional build macro SPI_SLAVE_ECHO_EN: on TX underrun the frame echoes the
// last word written to rx_data_o instead of shifting out zeros.
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dsize_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        ovr_o,
  output logic        udr_o,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Synchronizer chains plus one delayed copy for edge detection
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_nss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_nss_d;

  // Frame configuration, frozen while a frame window is open
  logic        r_cpol;
  logic        r_cpha;
  logic        r_lsb;
  logic [1:0]  r_dsize;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_tx_shift;
  logic [31:0] r_rx_shift;
  logic [31:0] r_rx_data;
  logic        r_rx_valid;
  logic        r_ovr;
  logic        r_miso;
  logic        r_miso_en;

  logic        w_sck;
  logic        w_nss;
  logic        w_mosi;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_nss_rise;
  logic        w_nss_fall;
  logic        w_lead;
  logic        w_trail;
  logic        w_sample;
  logic        w_shift;
  logic [4:0]  w_width_m1;
  logic [31:0] w_mask;
  logic [31:0] w_udr_word;
  logic [31:0] w_tx_word;
  logic [31:0] w_tx_aligned;
  logic        w_tx_first;
  logic [31:0] w_rx_next;
  logic [31:0] w_rx_word;
  logic        w_in_load;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_nss      = r_nss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_nss_rise = w_nss & ~r_nss_d;
  assign w_nss_fall = ~w_nss & r_nss_d;

  // Leading edge leaves the idle level; sample/shift roles swap with cpha
  assign w_lead   = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail  = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead  : w_trail;

  // Frame width minus one: 7, 15, 23, 31
  assign w_width_m1 = {r_dsize, 3'b111};
  assign w_mask     = 32'hFFFF_FFFF >> (5'd31 - w_width_m1);

`ifdef SPI_SLAVE_ECHO_EN
  assign w_udr_word = r_rx_data;
`else
  assign w_udr_word = 32'h0000_0000;
`endif

  // MSB-first words are left-aligned so the next bit is always bit 31
  assign w_tx_word    = tx_valid_i ? tx_data_i : w_udr_word;
  assign w_tx_aligned = w_tx_word << (5'd31 - w_width_m1);
  assign w_tx_first   = r_lsb ? w_tx_word[0] : w_tx_aligned[31];

  // MSB-first fills upward from bit 0; LSB-first enters at bit W-1 and moves down
  assign w_rx_next = r_lsb ? ((r_rx_shift >> 1) | ({31'b0, w_mosi} << w_width_m1))
                           : {r_rx_shift[30:0], w_mosi};
  assign w_rx_word = w_rx_next & w_mask;

  // A LOAD cycle aborted by NSS release neither pops nor reports underrun
  assign w_in_load = en_i & (r_state == ST_LOAD) & ~w_nss_rise;

  assign tx_ready_o    = w_in_load & tx_valid_i;
  assign udr_o         = w_in_load & ~tx_valid_i;
  assign busy_o        = en_i & ~w_nss;
  assign rx_valid_o    = r_rx_valid;
  assign rx_data_o     = r_rx_data;
  assign ovr_o         = r_ovr;
  assign spi_miso_o    = r_miso;
  assign spi_miso_en_o = r_miso_en;

  // Pin synchronizers; NSS chain rests high so reset never looks like a select
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sck_sync  <= '0;
      r_nss_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_nss_d     <= 1'b1;
    end else if (!en_i) begin
      r_sck_sync  <= '0;
      r_nss_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_nss_d     <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], spi_nss_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_sck_d     <= w_sck;
      r_nss_d     <= w_nss;
    end
  end

  // Frame engine: IDLE -> LOAD -> SHIFT, with RX handshake and overrun
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_en  <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_dsize    <= '0;
    end else if (!en_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_en  <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_dsize    <= '0;
    end else begin
      r_ovr <= 1'b0;
      if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
      if (w_nss_rise) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_rx_shift <= '0;
        r_miso     <= 1'b0;
        r_miso_en  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cpol    <= cpol_i;
            r_cpha    <= cpha_i;
            r_lsb     <= lsb_i;
            r_dsize   <= dsize_i;
            r_miso_en <= 1'b0;
            if (w_nss_fall) begin
              r_state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            r_miso     <= w_tx_first;
            r_tx_shift <= r_lsb ? (w_tx_word >> 1) : (w_tx_aligned << 1);
            r_miso_en  <= 1'b1;
            r_state    <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_sample) begin
              if (r_cnt == w_width_m1) begin
                r_cnt      <= '0;
                r_rx_shift <= '0;
                r_state    <= ST_LOAD;
                if (!r_rx_valid || rx_ready_i) begin
                  r_rx_data  <= w_rx_word;
                  r_rx_valid <= 1'b1;
                end else begin
                  r_ovr <= 1'b1;
                end
              end else begin
                r_cnt      <= r_cnt + 5'd1;
                r_rx_shift <= w_rx_next;
              end
            end else if (w_shift && (r_cnt != 5'd0)) begin
              // Counter 0 means the current bit was already placed (LOAD or
              // first cpha=1 leading edge) or the frame just closed.
              if (r_lsb) begin
                r_miso     <= r_tx_shift[0];
                r_tx_shift <= r_tx_shift >> 1;
              end else begin
                r_miso     <= r_tx_shift[31];
                r_tx_shift <= r_tx_shift << 1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: behavioural SPI master, TX FIFO
// model and RX capture, with expectations derived from the frame rules.
module tb_spi_slave_core;

  localparam int HP = 8;  // SCK half period in clk_i cycles

  logic        clk_i;
  logic        rst_n_i;
  logic        en_i;
  logic        cpol_i;
  logic        cpha_i;
  logic        lsb_i;
  logic [1:0]  dsize_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] tx_data_i;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] rx_data_o;
  logic        busy_o;
  logic        ovr_o;
  logic        udr_o;
  logic        spi_sck_i;
  logic        spi_nss_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic        spi_miso_en_o;

  int total;
  int bad;
  int tx_pops;
  int udr_cnt;
  int ovr_cnt;
  logic [31:0] txq[$];
  logic [31:0] rx_got[$];
  logic [31:0] mo_arr[4];
  logic [31:0] mi_arr[4];
  int s_pops;
  int s_udr;
  int s_ovr;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i), .dsize_i(dsize_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .busy_o(busy_o), .ovr_o(ovr_o), .udr_o(udr_o),
    .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // TX FIFO model: pops the head after a cycle in which tx_ready_o was high
  initial begin : tx_fifo_model
    logic p;
    tx_valid_i = 1'b0;
    tx_data_i  = 32'h0;
    tx_pops    = 0;
    forever begin
      @(negedge clk_i);
      p = tx_ready_o;
      @(posedge clk_i);
      #1;
      if (p && txq.size() > 0) begin
        void'(txq.pop_front());
        tx_pops++;
      end
      tx_valid_i = (txq.size() > 0);
      tx_data_i  = (txq.size() > 0) ? txq[0] : 32'h0;
    end
  end

  // Pulse counters and RX acceptance log
  initial begin : pulse_monitor
    udr_cnt = 0;
    ovr_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (udr_o) udr_cnt++;
      if (ovr_o) ovr_cnt++;
      if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic int width_of(input logic [1:0] d);
    return (int'(d) + 1) * 8;
  endfunction

  function automatic logic [31:0] trunc(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input logic cp, input logic ch, input logic lb, input logic [1:0] ds);
    cpol_i    = cp;
    cpha_i    = ch;
    lsb_i     = lb;
    dsize_i   = ds;
    spi_sck_i = cp;
    wait_clk(4);
  endtask

  // Behavioural master: one frame of nbits on an already-open NSS window
  task automatic spi_frame(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
    int w;
    int idx;
    w  = width_of(dsize_i);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb_i ? i : (w - 1 - i);
      if (!cpha_i) begin
        spi_mosi_i = mo[idx];
        wait_clk(HP);
        mi[idx]   = spi_miso_o;
        spi_sck_i = ~cpol_i;
        wait_clk(HP);
        spi_sck_i = cpol_i;
      end else begin
        wait_clk(HP);
        spi_sck_i  = ~cpol_i;
        spi_mosi_i = mo[idx];
        wait_clk(HP);
        mi[idx]   = spi_miso_o;
        spi_sck_i = cpol_i;
      end
    end
    $display("xfer cpol=%0d cpha=%0d lsb=%0d w=%0d bits=%0d mosi=%08h miso=%08h",
             cpol_i, cpha_i, lsb_i, w, nbits, mo, mi);
  endtask

  // One NSS window of nf frames; the last frame may be cut short
  task automatic run_window(input int nf, input int last_bits);
    logic [31:0] tmp;
    s_pops = tx_pops;
    s_udr  = udr_cnt;
    s_ovr  = ovr_cnt;
    spi_nss_i = 1'b0;
    wait_clk(4);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL busy_during_frame: got %0b required 1", busy_o);
    end
    for (int f = 0; f < nf; f++) begin
      spi_frame(mo_arr[f], (f == nf - 1) ? last_bits : width_of(dsize_i), tmp);
      mi_arr[f] = tmp;
    end
    wait_clk(HP);
    spi_nss_i = 1'b1;
    wait_clk(HP);
  endtask

  task automatic consume();
    rx_ready_i = 1'b1;
    wait_clk(1);
    rx_ready_i = 1'b0;
    wait_clk(1);
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    wait_clk(5);
    outs = {tx_ready_o, rx_valid_o, rx_data_o, busy_o, ovr_o, udr_o, spi_miso_o, spi_miso_en_o};
    total++;
    if (outs !== 40'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %010h required 0000000000", outs);
    end
    rst_n_i = 1'b1;
    wait_clk(5);
    total++;
    if ({busy_o, rx_valid_o, spi_miso_en_o} !== 3'b000) begin
      bad++;
      $display("FAIL after_reset_idle: got %03b required 000", {busy_o, rx_valid_o, spi_miso_en_o});
    end
  endtask

  task automatic test_basic();
    set_cfg(1'b0, 1'b0, 1'b0, 2'b00);
    txq.push_back(32'hA5);
    wait_clk(2);
    mo_arr[0] = 32'h3C;
    run_window(1, 8);
    total++;
    if (mi_arr[0] !== 32'hA5) begin
      bad++;
      $display("FAIL basic_miso: got %08h required 000000a5", mi_arr[0]);
    end
    total++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 32'h3C) begin
      bad++;
      $display("FAIL basic_rx: got valid=%0b data=%08h required valid=1 data=0000003c", rx_valid_o, rx_data_o);
    end
    total++;
    if (tx_pops - s_pops !== 1) begin
      bad++;
      $display("FAIL basic_tx_pops: got %0d required 1", tx_pops - s_pops);
    end
    // Completed frame reloads once more; FIFO is empty by then
    total++;
    if (udr_cnt - s_udr !== 1) begin
      bad++;
      $display("FAIL basic_udr_count: got %0d required 1", udr_cnt - s_udr);
    end
    consume();
    total++;
    if (rx_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_consume: got %0b required 0", rx_valid_o);
    end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      set_cfg(m[1], m[0], 1'b0, 2'b11);
      txq.push_back(32'h12345678);
      wait_clk(2);
      mo_arr[0] = 32'hDEADBEEF;
      run_window(1, 32);
      total++;
      if (rx_data_o !== 32'hDEADBEEF || rx_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL mode%0d_rx: got valid=%0b data=%08h required valid=1 data=deadbeef", m, rx_valid_o, rx_data_o);
      end
      total++;
      if (mi_arr[0] !== 32'h12345678) begin
        bad++;
        $display("FAIL mode%0d_miso: got %08h required 12345678", m, mi_arr[0]);
      end
      consume();
    end
  endtask

  task automatic test_lsb();
    set_cfg(1'b0, 1'b0, 1'b1, 2'b01);
    txq.push_back(32'h00FF);
    wait_clk(2);
    mo_arr[0] = 32'h8001;
    run_window(1, 16);
    total++;
    if (rx_data_o !== 32'h0000_8001) begin
      bad++;
      $display("FAIL lsb_rx: got %08h required 00008001", rx_data_o);
    end
    total++;
    if (mi_arr[0][0] !== 1'b1) begin
      bad++;
      $display("FAIL lsb_first_bit: got %0b required 1", mi_arr[0][0]);
    end
    total++;
    if (mi_arr[0] !== 32'h00FF) begin
      bad++;
      $display("FAIL lsb_miso: got %08h required 000000ff", mi_arr[0]);
    end
    consume();
  endtask

  task automatic test_overrun();
    set_cfg(1'b0, 1'b1, 1'b0, 2'b00);
    txq.push_back(32'hC3);
    txq.push_back(32'h96);
    wait_clk(2);
    mo_arr[0] = 32'h11;
    mo_arr[1] = 32'h22;
    rx_ready_i = 1'b0;
    run_window(2, 8);
    total++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 32'h11) begin
      bad++;
      $display("FAIL ovr_keep_old: got valid=%0b data=%08h required valid=1 data=00000011", rx_valid_o, rx_data_o);
    end
    total++;
    if (ovr_cnt - s_ovr !== 1) begin
      bad++;
      $display("FAIL ovr_pulses: got %0d required 1", ovr_cnt - s_ovr);
    end
    total++;
    if (mi_arr[0] !== 32'hC3 || mi_arr[1] !== 32'h96) begin
      bad++;
      $display("FAIL ovr_miso: got %08h %08h required 000000c3 00000096", mi_arr[0], mi_arr[1]);
    end
    consume();
  endtask

  task automatic test_underrun();
    logic [31:0] exp_udr;
    set_cfg(1'b0, 1'b0, 1'b0, 2'b00);
    txq.push_back(32'h3C);
    wait_clk(2);
    mo_arr[0] = 32'h5A;
    run_window(1, 8);
    consume();
    txq.delete();
    wait_clk(2);
    mo_arr[0] = 32'h00;
    run_window(1, 8);
`ifdef SPI_SLAVE_ECHO_EN
    exp_udr = 32'h5A;
`else
    exp_udr = 32'h00;
`endif
    total++;
    if (mi_arr[0] !== exp_udr) begin
      bad++;
      $display("FAIL udr_miso: got %08h required %08h", mi_arr[0], exp_udr);
    end
    // Start-of-window load and post-frame reload both find the FIFO empty
    total++;
    if (udr_cnt - s_udr !== 2 || tx_pops - s_pops !== 0) begin
      bad++;
      $display("FAIL udr_pulses: got udr=%0d pops=%0d required udr=2 pops=0", udr_cnt - s_udr, tx_pops - s_pops);
    end
    consume();
  endtask

  task automatic test_abort();
    logic [31:0] tmp;
    logic [39:0] outs;
    set_cfg(1'b0, 1'b0, 1'b0, 2'b00);
    txq.push_back(32'h81);
    wait_clk(2);
    mo_arr[0] = 32'hFF;
    run_window(1, 5);
    total++;
    if (rx_valid_o !== 1'b0 || ovr_cnt - s_ovr !== 0 || spi_miso_en_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_word: got valid=%0b ovr=%0d miso_en=%0b required 0 0 0",
               rx_valid_o, ovr_cnt - s_ovr, spi_miso_en_o);
    end
    txq.push_back(32'h42);
    wait_clk(2);
    mo_arr[0] = 32'h77;
    run_window(1, 8);
    total++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 32'h77 || mi_arr[0] !== 32'h42) begin
      bad++;
      $display("FAIL abort_next_frame: got valid=%0b rx=%08h miso=%08h required 1 00000077 00000042",
               rx_valid_o, rx_data_o, mi_arr[0]);
    end
    txq.push_back(32'h99);
    wait_clk(2);
    spi_nss_i = 1'b0;
    wait_clk(4);
    spi_frame(32'hAB, 3, tmp);
    rst_n_i = 1'b0;
    #1;
    outs = {tx_ready_o, rx_valid_o, rx_data_o, busy_o, ovr_o, udr_o, spi_miso_o, spi_miso_en_o};
    total++;
    if (outs !== 40'h0) begin
      bad++;
      $display("FAIL reset_midframe: got %010h required 0000000000", outs);
    end
    spi_nss_i = 1'b1;
    spi_sck_i = cpol_i;
    wait_clk(3);
    rst_n_i = 1'b1;
    txq.delete();
    wait_clk(5);
  endtask

  task automatic test_enable();
    logic [31:0] tmp;
    logic [39:0] outs;
    set_cfg(1'b1, 1'b0, 1'b0, 2'b00);
    txq.push_back(32'h10);
    wait_clk(2);
    mo_arr[0] = 32'hE7;
    run_window(1, 8);
    total++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 32'hE7) begin
      bad++;
      $display("FAIL en_setup: got valid=%0b data=%08h required 1 000000e7", rx_valid_o, rx_data_o);
    end
    txq.push_back(32'h20);
    wait_clk(2);
    spi_nss_i = 1'b0;
    wait_clk(4);
    spi_frame(32'h0F, 3, tmp);
    en_i = 1'b0;
    wait_clk(1);
    outs = {tx_ready_o, rx_valid_o, rx_data_o, busy_o, ovr_o, udr_o, spi_miso_o, spi_miso_en_o};
    total++;
    if (outs !== 40'h0) begin
      bad++;
      $display("FAIL en_low_clear: got %010h required 0000000000", outs);
    end
    spi_nss_i = 1'b1;
    spi_sck_i = cpol_i;
    wait_clk(3);
    en_i = 1'b1;
    txq.delete();
    wait_clk(5);
  endtask

  task automatic test_random();
    int nf;
    int w;
    logic [31:0] tx_w[4];
    rx_ready_i = 1'b1;
    for (int it = 0; it < 6; it++) begin
      rx_got.delete();
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      w  = width_of(dsize_i);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        tx_w[f]   = $urandom;
        mo_arr[f] = $urandom;
        txq.push_back(tx_w[f]);
      end
      wait_clk(2);
      run_window(nf, w);
      for (int f = 0; f < nf; f++) begin
        total++;
        if (mi_arr[f] !== trunc(tx_w[f], w)) begin
          bad++;
          $display("FAIL rand%0d_miso%0d: got %08h required %08h", it, f, mi_arr[f], trunc(tx_w[f], w));
        end
        total++;
        if (f >= rx_got.size()) begin
          bad++;
          $display("FAIL rand%0d_rx%0d: got no word required %08h", it, f, trunc(mo_arr[f], w));
        end else if (rx_got[f] !== trunc(mo_arr[f], w)) begin
          bad++;
          $display("FAIL rand%0d_rx%0d: got %08h required %08h", it, f, rx_got[f], trunc(mo_arr[f], w));
        end
      end
      total++;
      if (rx_got.size() != nf || ovr_cnt - s_ovr != 0 || udr_cnt - s_udr != 1 || tx_pops - s_pops != nf) begin
        bad++;
        $display("FAIL rand%0d_counts: got words=%0d ovr=%0d udr=%0d pops=%0d required %0d 0 1 %0d",
                 it, rx_got.size(), ovr_cnt - s_ovr, udr_cnt - s_udr, tx_pops - s_pops, nf, nf);
      end
    end
    rx_ready_i = 1'b0;
    txq.delete();
    wait_clk(2);
  endtask

  initial begin : main
    total      = 0;
    bad        = 0;
    rst_n_i    = 1'b0;
    en_i       = 1'b1;
    cpol_i     = 1'b0;
    cpha_i     = 1'b0;
    lsb_i      = 1'b0;
    dsize_i    = 2'b00;
    rx_ready_i = 1'b0;
    spi_sck_i  = 1'b0;
    spi_nss_i  = 1'b1;
    spi_mosi_i = 1'b0;
    test_reset();
    test_basic();
    test_modes();
    test_lsb();
    test_overrun();
    test_underrun();
    test_abort();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
